udp_rx_csum_check: RTL and testbench

- Inline checker on the UDP receive path, between the IP RX de-encapsulator and the UDP RX header/payload splitter.
- Accepts the IP pseudo-header and UDP header fields for one datagram, passes the UDP payload stream through unchanged, and computes the RFC 768 one's-complement checksum and byte length.
- Emits one result beat per datagram with checksum-OK and length-OK flags.
- Receive-side counterpart of the TX checksum/length generator.

---
 rtl/udp_rx_csum_check.sv | 276 +++++++++++++++++++++++++++
 tb/tb_udp_rx_csum_check.sv | 366 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/udp_rx_csum_check.sv
// Purpose : inline UDP receive checker; passes the payload through untouched while
//           accumulating the one's-complement checksum (pseudo-header + UDP header +
//           payload) and the payload byte count, then emits one result beat.
// Latency : payload pass-through is combinational (zero cycles); the result beat
//           appears after one FINAL cycle following the tlast handshake.
// Backpr. : m_axis_trdy feeds straight back to s_axis_trdy, and a stalled beat adds
//           nothing to the sum or count. The result is held until m_res_trdy.
//           No new header is taken until the result has been consumed.
//
// Ports:
//   i_clk, i_reset_n        clock, synchronous active-low reset
//   s_hdr_*                 IP pseudo-header + UDP header fields, valid/ready
//   s_axis_*                incoming UDP payload byte stream
//   m_axis_*                forwarded payload byte stream (same beats, same order)
//   m_res_*                 per-datagram result: checksum ok, length ok, byte count
//
// Only AXI_DATA_WIDTH = 8 is supported: the checksum pairing logic assumes one
// byte per beat.

module udp_rx_csum_check #(
   parameter int AXI_DATA_WIDTH = 8,
   parameter int MAX_PAYLOAD    = 1472
) (
   input  logic                      i_clk,
   input  logic                      i_reset_n,

   input  logic                      s_hdr_tvalid,
   output logic                      s_hdr_trdy,
   input  logic [31:0]               s_ip_src_ip_addr,
   input  logic [31:0]               s_ip_dst_ip_addr,
   input  logic [7:0]                s_ip_protocol,
   input  logic [15:0]               s_udp_src_port,
   input  logic [15:0]               s_udp_dst_port,
   input  logic [15:0]               s_udp_length,
   input  logic [15:0]               s_udp_checksum,

   input  logic [AXI_DATA_WIDTH-1:0] s_axis_tdata,
   input  logic                      s_axis_tvalid,
   input  logic                      s_axis_tlast,
   output logic                      s_axis_trdy,

   output logic [AXI_DATA_WIDTH-1:0] m_axis_tdata,
   output logic                      m_axis_tvalid,
   output logic                      m_axis_tlast,
   input  logic                      m_axis_trdy,

   output logic                      m_res_tvalid,
   input  logic                      m_res_trdy,
   output logic                      m_res_csum_ok,
   output logic                      m_res_len_ok,
   output logic [15:0]               m_res_byte_cnt
);

   localparam logic [15:0] MAX_PAYLOAD_W = 16'(MAX_PAYLOAD);
   localparam logic [3:0]  HDR_LAST_IDX  = 4'd9;   // ten header terms, indices 0..9

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_HDR_SUM,
      ST_PAYLOAD,
      ST_FINAL,
      ST_RESULT
   } state_t;

   state_t state_q, state_d;

   // Header fields captured at acceptance; inputs are ignored afterwards.
   logic [31:0] src_ip_q;
   logic [31:0] dst_ip_q;
   logic [7:0]  proto_q;
   logic [15:0] src_port_q;
   logic [15:0] dst_port_q;
   logic [15:0] udp_len_q;
   logic [15:0] udp_csum_q;

   // Running one's-complement sum, kept already folded to 16 bits.
   logic [15:0] sum_q;
   logic [3:0]  hdr_idx_q;
   logic [15:0] byte_cnt_q;
   logic [7:0]  held_byte_q;   // even-index byte waiting for its odd partner
   logic        odd_q;         // next payload byte has an odd index

   logic        res_csum_ok_q;
   logic        res_len_ok_q;
   logic [15:0] res_byte_cnt_q;

   logic        hdr_hs;
   logic        pay_hs;
   logic        res_hs;
   logic [7:0]  pay_byte;

   logic        add_en;
   logic [15:0] add_term;
   logic [16:0] sum_raw;
   logic [15:0] sum_fold;

   logic        fin_csum_ok;
   logic        fin_len_ok;

   assign pay_byte = s_axis_tdata[7:0];

   assign hdr_hs = (state_q == ST_IDLE)    && s_hdr_tvalid;
   assign pay_hs = (state_q == ST_PAYLOAD) && s_axis_tvalid && m_axis_trdy;
   assign res_hs = (state_q == ST_RESULT)  && m_res_trdy;

   // ------------------------------------------------------------------
   // Adder term selection: one header word per HDR_SUM cycle, one payload
   // word per odd-index handshake (or a zero-padded word for a trailing
   // even-index tlast byte).
   // ------------------------------------------------------------------
   always_comb begin
      add_en   = 1'b0;
      add_term = 16'h0000;
      case (state_q)
         ST_HDR_SUM: begin
            add_en = 1'b1;
            case (hdr_idx_q)
               4'd0:    add_term = src_ip_q[31:16];
               4'd1:    add_term = src_ip_q[15:0];
               4'd2:    add_term = dst_ip_q[31:16];
               4'd3:    add_term = dst_ip_q[15:0];
               4'd4:    add_term = {8'h00, proto_q};
               4'd5:    add_term = udp_len_q;      // pseudo-header length
               4'd6:    add_term = src_port_q;
               4'd7:    add_term = dst_port_q;
               4'd8:    add_term = udp_len_q;      // UDP header length
               4'd9:    add_term = udp_csum_q;
               default: add_term = 16'h0000;
            endcase
         end
         ST_PAYLOAD: begin
            if (pay_hs) begin
               if (odd_q) begin
                  add_en   = 1'b1;
                  add_term = {held_byte_q, pay_byte};
               end else if (s_axis_tlast) begin
                  add_en   = 1'b1;
                  add_term = {pay_byte, 8'h00};
               end
            end
         end
         default: begin
            add_en   = 1'b0;
            add_term = 16'h0000;
         end
      endcase
   end

   // End-around carry. Folding once is enough: the largest raw value is
   // 0x1FFFE, which folds to 0xFFFF without a second carry.
   assign sum_raw  = {1'b0, sum_q} + {1'b0, add_term};
   assign sum_fold = sum_raw[15:0] + {15'd0, sum_raw[16]};

   // A zero checksum field means the sender did not compute one.
   assign fin_csum_ok = (udp_csum_q == 16'h0000) || (sum_q == 16'hFFFF);

   // 17-bit compare so a saturated count cannot wrap into a false match.
   assign fin_len_ok = (({1'b0, byte_cnt_q} + 17'd8) == {1'b0, udp_len_q})
                       && (byte_cnt_q <= MAX_PAYLOAD_W)
                       && (udp_len_q >= 16'd8);

   // ------------------------------------------------------------------
   // Next state and handshake outputs
   // ------------------------------------------------------------------
   always_comb begin
      state_d       = state_q;
      s_hdr_trdy    = 1'b0;
      s_axis_trdy   = 1'b0;
      m_axis_tvalid = 1'b0;
      m_axis_tlast  = 1'b0;
      m_axis_tdata  = '0;
      case (state_q)
         ST_IDLE: begin
            s_hdr_trdy = 1'b1;
            if (s_hdr_tvalid) begin
               state_d = ST_HDR_SUM;
            end
         end
         ST_HDR_SUM: begin
            if (hdr_idx_q == HDR_LAST_IDX) begin
               state_d = ST_PAYLOAD;
            end
         end
         ST_PAYLOAD: begin
            s_axis_trdy   = m_axis_trdy;
            m_axis_tvalid = s_axis_tvalid;
            m_axis_tlast  = s_axis_tlast;
            m_axis_tdata  = s_axis_tdata;
            if (pay_hs && s_axis_tlast) begin
               state_d = ST_FINAL;
            end
         end
         ST_FINAL: begin
            state_d = ST_RESULT;
         end
         ST_RESULT: begin
            // Header ready stays low here even on the handshake cycle.
            if (res_hs) begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // ------------------------------------------------------------------
   // State and datapath registers
   // ------------------------------------------------------------------
   always_ff @(posedge i_clk) begin
      if (!i_reset_n) begin
         state_q        <= ST_IDLE;
         src_ip_q       <= 32'd0;
         dst_ip_q       <= 32'd0;
         proto_q        <= 8'd0;
         src_port_q     <= 16'd0;
         dst_port_q     <= 16'd0;
         udp_len_q      <= 16'd0;
         udp_csum_q     <= 16'd0;
         sum_q          <= 16'd0;
         hdr_idx_q      <= 4'd0;
         byte_cnt_q     <= 16'd0;
         held_byte_q    <= 8'd0;
         odd_q          <= 1'b0;
         res_csum_ok_q  <= 1'b0;
         res_len_ok_q   <= 1'b0;
         res_byte_cnt_q <= 16'd0;
      end else begin
         state_q <= state_d;

         if (hdr_hs) begin
            src_ip_q    <= s_ip_src_ip_addr;
            dst_ip_q    <= s_ip_dst_ip_addr;
            proto_q     <= s_ip_protocol;
            src_port_q  <= s_udp_src_port;
            dst_port_q  <= s_udp_dst_port;
            udp_len_q   <= s_udp_length;
            udp_csum_q  <= s_udp_checksum;
            sum_q       <= 16'd0;
            hdr_idx_q   <= 4'd0;
            byte_cnt_q  <= 16'd0;
            held_byte_q <= 8'd0;
            odd_q       <= 1'b0;
         end else if (add_en) begin
            sum_q <= sum_fold;
         end

         if (state_q == ST_HDR_SUM) begin
            hdr_idx_q <= hdr_idx_q + 4'd1;
         end

         if (pay_hs) begin
            if (byte_cnt_q != 16'hFFFF) begin
               byte_cnt_q <= byte_cnt_q + 16'd1;
            end
            if (!odd_q) begin
               held_byte_q <= pay_byte;
            end
            odd_q <= !odd_q;
         end

         if (state_q == ST_FINAL) begin
            res_csum_ok_q  <= fin_csum_ok;
            res_len_ok_q   <= fin_len_ok;
            res_byte_cnt_q <= byte_cnt_q;
         end
      end
   end

   assign m_res_tvalid   = (state_q == ST_RESULT);
   assign m_res_csum_ok  = res_csum_ok_q;
   assign m_res_len_ok   = res_len_ok_q;
   assign m_res_byte_cnt = res_byte_cnt_q;

endmodule

// File: tb/tb_udp_rx_csum_check.sv
// Bench for udp_rx_csum_check: directed datagrams plus randomized ones with
// random backpressure, checked against a plain-arithmetic checksum model.
// Inputs are driven on the falling edge; outputs are sampled 1 time unit later.

module tb_udp_rx_csum_check;

   logic        i_clk = 1'b0;
   logic        i_reset_n;
   logic        s_hdr_tvalid;
   logic        s_hdr_trdy;
   logic [31:0] s_ip_src_ip_addr;
   logic [31:0] s_ip_dst_ip_addr;
   logic [7:0]  s_ip_protocol;
   logic [15:0] s_udp_src_port;
   logic [15:0] s_udp_dst_port;
   logic [15:0] s_udp_length;
   logic [15:0] s_udp_checksum;
   logic [7:0]  s_axis_tdata;
   logic        s_axis_tvalid;
   logic        s_axis_tlast;
   logic        s_axis_trdy;
   logic [7:0]  m_axis_tdata;
   logic        m_axis_tvalid;
   logic        m_axis_tlast;
   logic        m_axis_trdy;
   logic        m_res_tvalid;
   logic        m_res_trdy;
   logic        m_res_csum_ok;
   logic        m_res_len_ok;
   logic [15:0] m_res_byte_cnt;

   always #5 i_clk = ~i_clk;

   udp_rx_csum_check #(.AXI_DATA_WIDTH(8), .MAX_PAYLOAD(1472)) dut (
      .i_clk            (i_clk),
      .i_reset_n        (i_reset_n),
      .s_hdr_tvalid     (s_hdr_tvalid),
      .s_hdr_trdy       (s_hdr_trdy),
      .s_ip_src_ip_addr (s_ip_src_ip_addr),
      .s_ip_dst_ip_addr (s_ip_dst_ip_addr),
      .s_ip_protocol    (s_ip_protocol),
      .s_udp_src_port   (s_udp_src_port),
      .s_udp_dst_port   (s_udp_dst_port),
      .s_udp_length     (s_udp_length),
      .s_udp_checksum   (s_udp_checksum),
      .s_axis_tdata     (s_axis_tdata),
      .s_axis_tvalid    (s_axis_tvalid),
      .s_axis_tlast     (s_axis_tlast),
      .s_axis_trdy      (s_axis_trdy),
      .m_axis_tdata     (m_axis_tdata),
      .m_axis_tvalid    (m_axis_tvalid),
      .m_axis_tlast     (m_axis_tlast),
      .m_axis_trdy      (m_axis_trdy),
      .m_res_tvalid     (m_res_tvalid),
      .m_res_trdy       (m_res_trdy),
      .m_res_csum_ok    (m_res_csum_ok),
      .m_res_len_ok     (m_res_len_ok),
      .m_res_byte_cnt   (m_res_byte_cnt)
   );

   int tests = 0;
   int fails = 0;

   // Current datagram as the bench sees it
   logic [31:0] h_src, h_dst;
   logic [7:0]  h_proto;
   logic [15:0] h_sp, h_dp, h_len, h_csum;
   logic [7:0]  pl[$];
   logic [7:0]  rx[$];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // ---------------- reference model ----------------
   // Whole-datagram one's-complement sum: add every 16-bit word in a wide
   // accumulator, then fold carries back until it fits in 16 bits.
   function automatic logic [15:0] ref_fold(input logic [15:0] csum_field);
      longint unsigned acc;
      acc = 0;
      acc += 64'(h_src[31:16]);
      acc += 64'(h_src[15:0]);
      acc += 64'(h_dst[31:16]);
      acc += 64'(h_dst[15:0]);
      acc += 64'(h_proto);
      acc += 64'(h_len);
      acc += 64'(h_sp);
      acc += 64'(h_dp);
      acc += 64'(h_len);
      acc += 64'(csum_field);
      for (int i = 0; i < pl.size(); i += 2) begin
         acc += 64'(pl[i]) << 8;
         if (i + 1 < pl.size()) acc += 64'(pl[i+1]);
      end
      while (acc > 64'hFFFF) acc = (acc & 64'hFFFF) + (acc >> 16);
      return acc[15:0];
   endfunction

   function automatic logic model_csum_ok();
      return (h_csum == 16'h0000) || (ref_fold(h_csum) == 16'hFFFF);
   endfunction

   function automatic logic model_len_ok();
      return (pl.size() + 8 == int'(h_len)) && (pl.size() <= 1472) && (h_len >= 16'd8);
   endfunction

   // ---------------- driver / monitor tasks ----------------
   task automatic send_hdr();
      int w;
      @(negedge i_clk);
      s_hdr_tvalid     = 1'b1;
      s_ip_src_ip_addr = h_src;
      s_ip_dst_ip_addr = h_dst;
      s_ip_protocol    = h_proto;
      s_udp_src_port   = h_sp;
      s_udp_dst_port   = h_dp;
      s_udp_length     = h_len;
      s_udp_checksum   = h_csum;
      #1;
      w = 0;
      while (!s_hdr_trdy && w < 50) begin
         @(negedge i_clk); #1; w++;
      end
      chk("hdr_accept_in_time", 32'(w < 50), 32'd1);
      @(posedge i_clk); #1;
      // Garbage on the header bus after acceptance must not disturb the datagram
      s_hdr_tvalid     = 1'b0;
      s_ip_src_ip_addr = $urandom;
      s_ip_dst_ip_addr = $urandom;
      s_ip_protocol    = 8'($urandom);
      s_udp_src_port   = 16'($urandom);
      s_udp_dst_port   = 16'($urandom);
      s_udp_length     = 16'($urandom);
      s_udp_checksum   = 16'($urandom);
   endtask

   task automatic send_payload(input bit rand_bp);
      int  idx = 0;
      int  cyc = 0;
      int  first_rdy = -1;
      int  leak = 0;
      int  budget;
      bit  done = 0;
      bit  tlast_bad = 0;
      bit  data_ok;
      budget = pl.size() * 10 + 200;
      rx.delete();
      while (!done && cyc < budget) begin
         @(negedge i_clk);
         s_axis_tvalid = rand_bp ? ($urandom_range(0, 3) != 0) : 1'b1;
         s_axis_tdata  = pl[idx];
         s_axis_tlast  = (idx == pl.size() - 1);
         m_axis_trdy   = rand_bp ? ($urandom_range(0, 2) != 0) : 1'b1;
         #1;
         if (m_axis_tvalid && m_axis_trdy) begin
            rx.push_back(m_axis_tdata);
            if (m_axis_tlast !== (idx == pl.size() - 1)) tlast_bad = 1;
         end
         // The ten header-sum cycles must not move any payload
         if (cyc < 10 && (m_axis_tvalid || s_axis_trdy)) leak++;
         if (s_axis_trdy && first_rdy < 0) first_rdy = cyc;
         if (s_axis_tvalid && s_axis_trdy) begin
            idx++;
            if (idx == pl.size()) done = 1;
         end
         cyc++;
      end
      chk("payload_done_in_time", 32'(done), 32'd1);
      data_ok = (rx.size() == pl.size());
      if (data_ok)
         for (int i = 0; i < pl.size(); i++) if (rx[i] !== pl[i]) data_ok = 0;
      chk("payload_forwarded_unchanged", 32'(data_ok), 32'd1);
      chk("forwarded_tlast", 32'(tlast_bad), 32'd0);
      chk("no_payload_during_hdr_sum", 32'(leak), 32'd0);
      if (!rand_bp) chk("payload_ready_after_10_hdr_cycles", 32'(first_rdy), 32'd10);
   endtask

   task automatic check_result(input int hold, input logic exp_cs, input logic exp_len,
                               input logic [15:0] exp_cnt);
      int lat;
      bit stable = 1;
      @(negedge i_clk);
      s_axis_tvalid = 1'b0;
      s_axis_tlast  = 1'b0;
      m_res_trdy    = 1'b0;
      #1;
      lat = 1;
      while (!m_res_tvalid && lat < 20) begin
         @(negedge i_clk); #1; lat++;
      end
      // One FINAL cycle sits between the tlast handshake and the result beat
      chk("result_latency", 32'(lat), 32'd2);
      chk("csum_ok", 32'(m_res_csum_ok), 32'(exp_cs));
      chk("len_ok", 32'(m_res_len_ok), 32'(exp_len));
      chk("byte_cnt", 32'(m_res_byte_cnt), 32'(exp_cnt));
      for (int i = 0; i < hold; i++) begin
         @(negedge i_clk); #1;
         if (!m_res_tvalid || m_res_csum_ok !== exp_cs || m_res_len_ok !== exp_len ||
             m_res_byte_cnt !== exp_cnt || s_hdr_trdy) stable = 0;
      end
      if (hold > 0) chk("result_held_stable", 32'(stable), 32'd1);
      m_res_trdy = 1'b1;
      chk("hdr_rdy_low_on_result_hs", 32'(s_hdr_trdy), 32'd0);
      @(negedge i_clk);
      m_res_trdy = 1'b0;
      #1;
      chk("result_dropped_after_hs", 32'(m_res_tvalid), 32'd0);
      chk("hdr_rdy_after_result_hs", 32'(s_hdr_trdy), 32'd1);
   endtask

   task automatic set_dgram1();
      h_src   = 32'hC0A8_0101;
      h_dst   = 32'hC0A8_0102;
      h_proto = 8'd17;
      h_sp    = 16'd1234;
      h_dp    = 16'd5678;
      h_len   = 16'd12;
      h_csum  = 16'hC3E4;
      pl      = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
   endtask

   task automatic fill_random(input int n);
      pl.delete();
      for (int i = 0; i < n; i++) pl.push_back(8'($urandom));
   endtask

   // Watchdog: the stimulus bounds its own waits, this only catches a stuck bench
   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int cnt;
      int cyc;
      int seen;
      int n;
      int mode;

      i_reset_n        = 1'b0;
      s_hdr_tvalid     = 1'b0;
      s_ip_src_ip_addr = '0;
      s_ip_dst_ip_addr = '0;
      s_ip_protocol    = '0;
      s_udp_src_port   = '0;
      s_udp_dst_port   = '0;
      s_udp_length     = '0;
      s_udp_checksum   = '0;
      s_axis_tdata     = '0;
      s_axis_tvalid    = 1'b0;
      s_axis_tlast     = 1'b0;
      m_axis_trdy      = 1'b0;
      m_res_trdy       = 1'b0;

      // ---- reset state ----
      repeat (3) @(negedge i_clk);
      #1;
      chk("reset_hdr_trdy", 32'(s_hdr_trdy), 32'd1);
      chk("reset_s_axis_trdy", 32'(s_axis_trdy), 32'd0);
      chk("reset_m_axis_tvalid", 32'(m_axis_tvalid), 32'd0);
      chk("reset_m_res_tvalid", 32'(m_res_tvalid), 32'd0);
      chk("reset_byte_cnt", 32'(m_res_byte_cnt), 32'd0);
      i_reset_n = 1'b1;

      // ---- good datagram ----
      set_dgram1();
      send_hdr(); send_payload(0); check_result(0, 1'b1, 1'b1, 16'd4);

      // ---- wrong checksum, then checksum disabled ----
      set_dgram1(); h_csum = 16'hC3E5;
      send_hdr(); send_payload(0); check_result(0, 1'b0, 1'b1, 16'd4);
      set_dgram1(); h_csum = 16'h0000;
      send_hdr(); send_payload(0); check_result(0, 1'b1, 1'b1, 16'd4);

      // ---- odd payload, last byte padded to BE00; C4D5 is its correct checksum ----
      set_dgram1(); h_len = 16'd11; h_csum = 16'hC4D5;
      pl = '{8'hDE, 8'hAD, 8'hBE};
      send_hdr(); send_payload(0); check_result(0, 1'b1, 1'b1, 16'd3);

      // ---- length field larger than the data (early tlast) ----
      set_dgram1(); h_len = 16'd16;
      send_hdr(); send_payload(0); check_result(0, 1'b0, 1'b0, 16'd4);

      // ---- one byte over the payload limit, then exactly at the limit ----
      set_dgram1(); fill_random(1473); h_len = 16'd1481; h_csum = 16'h0000;
      send_hdr(); send_payload(0); check_result(0, 1'b1, 1'b0, 16'd1473);
      set_dgram1(); fill_random(1472); h_len = 16'd1480; h_csum = 16'h0000;
      send_hdr(); send_payload(0); check_result(0, 1'b1, 1'b1, 16'd1472);

      // ---- good datagram under random backpressure, result held 5 cycles ----
      set_dgram1();
      send_hdr(); send_payload(1); check_result(5, 1'b1, 1'b1, 16'd4);

      // ---- randomized datagrams against the model ----
      for (int t = 0; t < 10; t++) begin
         n       = $urandom_range(1, 40);
         h_src   = $urandom;
         h_dst   = $urandom;
         h_proto = 8'($urandom);
         h_sp    = 16'($urandom);
         h_dp    = 16'($urandom);
         fill_random(n);
         mode  = $urandom_range(0, 3);
         h_len = (mode == 3) ? 16'(n + 8 + $urandom_range(1, 5)) : 16'(n + 8);
         h_csum = 16'h0000;
         if (mode == 0 || mode == 3) h_csum = ~ref_fold(16'h0000);
         else if (mode == 1)         h_csum = ~ref_fold(16'h0000) ^ 16'h0010;
         send_hdr();
         send_payload(1);
         check_result($urandom_range(0, 3), model_csum_ok(), model_len_ok(), 16'(n));
      end

      // ---- reset in the middle of a datagram ----
      set_dgram1();
      send_hdr();
      cnt = 0;
      cyc = 0;
      while (cnt < 2 && cyc < 100) begin
         @(negedge i_clk);
         s_axis_tvalid = 1'b1;
         s_axis_tdata  = pl[cnt];
         s_axis_tlast  = 1'b0;
         m_axis_trdy   = 1'b1;
         #1;
         if (s_axis_trdy) cnt++;
         cyc++;
      end
      chk("reset_test_two_bytes_sent", 32'(cnt), 32'd2);
      @(negedge i_clk);
      i_reset_n     = 1'b0;
      s_axis_tvalid = 1'b1;
      s_axis_tdata  = pl[2];
      @(negedge i_clk);
      i_reset_n = 1'b1;
      #1;
      chk("midrst_m_axis_tvalid", 32'(m_axis_tvalid), 32'd0);
      chk("midrst_m_axis_tdata", 32'(m_axis_tdata), 32'd0);
      chk("midrst_m_axis_tlast", 32'(m_axis_tlast), 32'd0);
      chk("midrst_s_axis_trdy", 32'(s_axis_trdy), 32'd0);
      chk("midrst_m_res_tvalid", 32'(m_res_tvalid), 32'd0);
      chk("midrst_csum_ok", 32'(m_res_csum_ok), 32'd0);
      chk("midrst_len_ok", 32'(m_res_len_ok), 32'd0);
      chk("midrst_byte_cnt", 32'(m_res_byte_cnt), 32'd0);
      chk("midrst_idle_hdr_trdy", 32'(s_hdr_trdy), 32'd1);
      s_axis_tvalid = 1'b0;
      seen = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge i_clk); #1;
         if (m_res_tvalid) seen++;
      end
      chk("midrst_no_result", 32'(seen), 32'd0);

      // ---- clean datagram after the abandoned one ----
      set_dgram1();
      send_hdr(); send_payload(0); check_result(0, 1'b1, 1'b1, 16'd4);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
